vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares a single-port synchronous framebuffer RAM between three users:
  - the VGA scan-out reader (hard priority),
  - a built-in clear engine,
  - a draw/sprite writer (req/gnt handshake).
- Sits between the pattern/scan-out logic and a 64x48-cell, 3-bit RGB framebuffer. Each cell covers 10x10 screen pixels.
- Runs entirely in the 25 MHz pixel clock domain.

Parameters:
- ADDR_W, 12, framebuffer address width.
- DATA_W, 3, cell colour width ({r,g,b}).
- FB_DEPTH, 3072, number of cells (64*48); clear sweeps 0..FB_DEPTH-1.
- STALL_W, 16, width of the writer-stall statistics counter.

Ports:
- clk25MHz  in  1  pixel clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- disp_req  in  1  scan-out needs a cell this cycle; always served the same cycle.
- disp_addr  in  ADDR_W  cell address for disp_req.
- disp_valid  out  1  one-cycle pulse: disp_data updated.
- disp_data  out  DATA_W  registered cell colour, held between pulses.
- wr_req  in  1  writer request; held with addr/data stable until granted.
- wr_addr  in  ADDR_W  writer address.
- wr_data  in  DATA_W  writer colour.
- wr_gnt  out  1  combinational; write performed this cycle.
- clear_start  in  1  pulse: start a full-framebuffer clear.
- clear_color  in  DATA_W  fill colour, sampled on the accepted clear_start.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- wr_stall_cnt  out  STALL_W  saturating count of cycles with wr_req=1 and wr_gnt=0.
- ram_addr  out  ADDR_W  RAM address (combinational mux).
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after its address.

Behaviour:
- Reset values (async, resetn=0):
  - disp_valid=0, disp_data=0, clear_busy=0, clear_done=0, wr_stall_cnt=0.
  - FSM=IDLE, clear pointer=0, internal pipeline flags=0.
  - With resetn=0: ram_we=0, wr_gnt=0.
- Slot priority per cycle (exactly one owner): disp_req > clear engine (FSM=CLEAR) > writer.
- Display slot: ram_addr=disp_addr, ram_we=0.
  - Cycle N: disp_req. Cycle N+1: capture ram_rdata into disp_data. Cycle N+2: disp_valid=1.
  - Fixed 2-cycle latency; back-to-back disp_req is legal, one pulse each.
- Clear slot: ram_addr=clr_ptr, ram_we=1, ram_wdata=latched colour; clr_ptr increments only on slots the clear engine owns.
- Writer slot: taken only if wr_req=1, FSM=IDLE and no disp_req.
  - In that cycle: wr_gnt=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - The writer drops or changes its request after the granted edge.
- No owner: ram_we=0, ram_addr=0.
- FSM:
  - IDLE -> CLEAR on clear_start: latch clear_color, clr_ptr=0, clear_busy=1.
  - CLEAR -> DONE when a clear write occurs at clr_ptr=FB_DEPTH-1.
  - DONE (one cycle): clear_done=1, clear_busy=0; then -> IDLE.
  - clear_start in CLEAR or DONE is ignored (colour not re-latched).
- wr_gnt=0 throughout CLEAR and DONE; the writer is only ever stalled, never dropped.
- wr_stall_cnt increments each cycle with wr_req & ~wr_gnt and saturates at all-ones.
- resetn asserted mid-clear: abort immediately to IDLE, no clear_done, partial contents left as is.
- Simultaneous clear_start and wr_req in IDLE: the writer is granted that cycle (FSM still IDLE); CLEAR begins the next cycle.
- Scan-out pattern (1 disp_req per 10 active pixels) guarantees ≥9 free slots per 10 cycles. The arbiter itself does not rely on this; it is correct for any disp_req pattern, including a continuous one (writer and clear then stall indefinitely).

Decomposition:
- Package vga_fb_pkg:
  - FB_COLS=64, FB_ROWS=48, FB_DEPTH, CELL_PX=10, ADDR_W, DATA_W.
  - FSM state enum {IDLE, CLEAR, DONE}.
  - Owner enum {OWN_NONE, OWN_DISP, OWN_CLR, OWN_WR}.
- Sub-module vga_fb_clear_seq: the FSM, pointer and colour latch.
  - Inputs: slot_granted, clear_start, clear_color.
  - Outputs: busy, done, clr_addr, clr_data.
- The top keeps the priority mux, display pipeline and stall counter.

Test Plan:
1. Reset: hold resetn=0 with all inputs toggling -> all outputs 0, ram_we=0. Release -> FSM=IDLE, no spurious pulses.
2. Display latency: disp_req=1 at addr 0x005 with RAM cell 0x005=3'b101 -> disp_valid pulses 2 cycles later with disp_data=3'b101. Three back-to-back reads -> three consecutive valid pulses carrying the correct data.
3. Contention: wr_req with wr_addr=0x010, wr_data=3'b011 while disp_req=1 for 3 cycles:
   - wr_gnt=0 for 3 cycles, wr_stall_cnt=3;
   - on cycle 4, wr_gnt=1, ram_we=1, addr 0x010 written.
4. Full clear, clear_color=3'b100, disp_req every 10th cycle:
   - clear_busy stays high for exactly 3072 + (number of display slots) cycles;
   - single clear_done pulse;
   - RAM model holds 3'b100 in all 3072 cells;
   - wr_gnt=0 throughout even with wr_req=1.
5. Mid-clear reset: assert resetn=0 at clr_ptr=1000 -> busy drops asynchronously and no clear_done. After release, clear_start with colour 3'b001 sweeps again from 0.
6. Stall saturation with STALL_W=4: wr_req=1 during a clear lasting more than 15 cycles -> wr_stall_cnt sticks at 15 and does not wrap.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared geometry, widths and state encodings for the framebuffer arbiter.
// The framebuffer is 64x48 cells, each cell covering 10x10 screen pixels.
package vga_fb_pkg;

    localparam int FB_COLS  = 64;
    localparam int FB_ROWS  = 48;
    localparam int FB_DEPTH = FB_COLS * FB_ROWS;
    localparam int CELL_PX  = 10;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 3;
    localparam int STALL_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CLR  = 2'd2,
        OWN_WR   = 2'd3
    } owner_e;

endpackage

// File: rtl/vga_fb_clear_seq.sv
// Clear engine: sweeps every framebuffer cell with a latched colour, advancing
// only on cycles where the arbiter hands it the RAM slot.
module vga_fb_clear_seq #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 3,
    parameter int FB_DEPTH = 3072
) (
    input  logic              clk25MHz,
    input  logic              resetn,
    input  logic              slot_granted,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data
);
    import vga_fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    clr_state_e        state;
    clr_state_e        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] color;
    logic              wrote;

    assign wrote = (state == CLEAR) && slot_granted;

    always_ff @(posedge clk25MHz or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clear_start) state_nxt = CLEAR;
            CLEAR:   if (wrote && ptr == LAST_ADDR) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
        done = (state == DONE);
    end

    // Colour is only latched from IDLE, so restarts during a sweep are ignored.
    always_ff @(posedge clk25MHz or negedge resetn) begin
        if (!resetn) begin
            ptr   <= '0;
            color <= '0;
        end else if (state == IDLE && clear_start) begin
            ptr   <= '0;
            color <= clear_color;
        end else if (wrote) begin
            ptr   <= ptr + ADDR_W'(1);
        end
    end

    assign clr_addr = ptr;
    assign clr_data = color;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads win every cycle they ask,
// then the clear engine, then the draw writer via a combinational grant.
module vga_fb_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 3,
    parameter int FB_DEPTH = 3072,
    parameter int STALL_W  = 16
) (
    input  logic               clk25MHz,
    input  logic               resetn,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic               disp_valid,
    output logic [DATA_W-1:0]  disp_data,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_gnt,
    input  logic               clear_start,
    input  logic [DATA_W-1:0]  clear_color,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [STALL_W-1:0] wr_stall_cnt,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata
);
    import vga_fb_pkg::*;

    owner_e            owner;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic [2:1]        vld_pipe;

    vga_fb_clear_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FB_DEPTH (FB_DEPTH)
    ) u_clear (
        .clk25MHz     (clk25MHz),
        .resetn       (resetn),
        .slot_granted (owner == OWN_CLR),
        .clear_start  (clear_start),
        .clear_color  (clear_color),
        .busy         (clr_busy),
        .done         (clr_done),
        .clr_addr     (clr_addr),
        .clr_data     (clr_data)
    );

    // Writer is held off for the whole CLEAR and DONE window, not just CLEAR.
    always_comb begin
        owner = OWN_NONE;
        if (resetn) begin
            if (disp_req)                            owner = OWN_DISP;
            else if (clr_busy)                       owner = OWN_CLR;
            else if (wr_req && !clr_busy && !clr_done) owner = OWN_WR;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        wr_gnt    = 1'b0;
        unique case (owner)
            OWN_DISP: ram_addr = disp_addr;
            OWN_CLR: begin
                ram_addr  = clr_addr;
                ram_we    = 1'b1;
                ram_wdata = clr_data;
            end
            OWN_WR: begin
                ram_addr  = wr_addr;
                ram_we    = 1'b1;
                ram_wdata = wr_data;
                wr_gnt    = 1'b1;
            end
            default: ;
        endcase
    end

    // Read issued in N, RAM data arrives in N+1 and is captured, pulse in N+2.
    always_ff @(posedge clk25MHz or negedge resetn) begin
        if (!resetn) begin
            vld_pipe  <= '0;
            disp_data <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[1], owner == OWN_DISP};
            if (vld_pipe[1]) disp_data <= ram_rdata;
        end
    end

    assign disp_valid = vld_pipe[2];

    always_ff @(posedge clk25MHz or negedge resetn) begin
        if (!resetn)
            wr_stall_cnt <= '0;
        else if (wr_req && !wr_gnt && wr_stall_cnt != {STALL_W{1'b1}})
            wr_stall_cnt <= wr_stall_cnt + STALL_W'(1);
    end

    assign clear_busy = clr_busy;
    assign clear_done = clr_done;

endmodule
